// File: rtl/sig_dump_dma.sv
// Signature dump engine: programmed over a device port, reads RAM[BEGIN..END)
// as a bus host and streams the words to a valid/ready sink.
module sig_dump_dma #(
  parameter int FifoDepth = 4,
  parameter int CntWidth  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dev_req_i,
  input  logic        dev_we_i,
  input  logic [31:0] dev_addr_i,
  input  logic [3:0]  dev_be_i,
  input  logic [31:0] dev_wdata_i,
  output logic        dev_rvalid_o,
  output logic [31:0] dev_rdata_o,
  output logic        dev_err_o,
  output logic        host_req_o,
  input  logic        host_gnt_i,
  output logic [31:0] host_addr_o,
  input  logic        host_rvalid_i,
  input  logic [31:0] host_rdata_i,
  input  logic        host_err_i,
  output logic        sig_valid_o,
  input  logic        sig_ready_i,
  output logic [31:0] sig_data_o,
  output logic        sig_last_o
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int OccW = PtrW + 1;
  localparam logic [OccW:0] DepthW  = (OccW + 1)'(FifoDepth);
  localparam logic [31:0]   MaxWords = 32'((64'd1 << CntWidth) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e              state_r, state_s;
  logic [31:0]         begin_r, end_r, addr_r;
  logic                done_r, err_r;
  logic [CntWidth-1:0] count_r, total_r;
  logic [OccW-1:0]     outst_r, fifo_cnt_r;
  logic [PtrW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [31:0]         fifo_mem_r [FifoDepth];
  logic                dev_rvalid_r, dev_err_r;
  logic [31:0]         dev_rdata_r;

  logic        busy_s, wr_begin_s, wr_end_s, start_s, dev_err_s;
  logic [31:0] dev_rdata_s, span_s, words_s;
  logic [2:0]  dev_off_s;
  logic        start_bad_s, start_empty_s, start_go_s;
  logic        host_req_s, credit_ok_s, grant_s, push_s, pop_s, sig_valid_s;
  logic        drain_done_s;
  logic        unused_s;

  assign busy_s    = (state_r != ST_IDLE);
  assign dev_off_s = dev_addr_i[4:2];
  assign unused_s  = ^{dev_addr_i[31:5], dev_addr_i[1:0], dev_wdata_i[31:1]};

  // Device port decode: register writes, START, read data and error response.
  always_comb begin
    wr_begin_s  = 1'b0;
    wr_end_s    = 1'b0;
    start_s     = 1'b0;
    dev_err_s   = 1'b0;
    dev_rdata_s = 32'd0;
    if (dev_req_i) begin
      if (dev_we_i) begin
        if (dev_be_i != 4'hF) begin
          dev_err_s = 1'b1;
        end else begin
          case (dev_off_s)
            3'd0: if (busy_s) dev_err_s = 1'b1; else wr_begin_s = 1'b1;
            3'd1: if (busy_s) dev_err_s = 1'b1; else wr_end_s = 1'b1;
            3'd2: if (busy_s) dev_err_s = 1'b1; else start_s = dev_wdata_i[0];
            default: dev_err_s = 1'b1;
          endcase
        end
      end else begin
        case (dev_off_s)
          3'd0:    dev_rdata_s = begin_r;
          3'd1:    dev_rdata_s = end_r;
          3'd2:    dev_rdata_s = 32'd0;
          3'd3:    dev_rdata_s = {29'd0, err_r, done_r, busy_s};
          3'd4:    dev_rdata_s = {{(32-CntWidth){1'b0}}, count_r};
          default: dev_err_s = 1'b1;
        endcase
      end
    end else begin
      dev_err_s   = 1'b0;
      dev_rdata_s = 32'd0;
    end
  end

  // Range checks on the programmed window, evaluated when START arrives.
  always_comb begin
    span_s        = end_r - begin_r;
    words_s       = span_s >> 2;
    start_empty_s = (end_r == begin_r);
    start_bad_s   = (begin_r[1:0] != 2'b00) || (end_r[1:0] != 2'b00) ||
                    (end_r < begin_r) || (words_s > MaxWords);
    start_go_s    = start_s && !start_bad_s && !start_empty_s;
  end

  // Host credit, handshakes and stream-side pop.
  always_comb begin
    credit_ok_s = (({1'b0, outst_r} + {1'b0, fifo_cnt_r}) < DepthW);
    host_req_s  = (state_r == ST_RUN) && credit_ok_s;
    grant_s     = host_req_s && host_gnt_i;
    push_s      = host_rvalid_i && (outst_r != {OccW{1'b0}});
    sig_valid_s = (fifo_cnt_r != {OccW{1'b0}});
    pop_s       = sig_valid_s && sig_ready_i;
  end

  // FSM next-state logic.
  always_comb begin
    state_s      = state_r;
    drain_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_go_s) state_s = ST_RUN;
        else            state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (grant_s && ((addr_r + 32'd4) == end_r)) state_s = ST_DRAIN;
        else                                        state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if ((outst_r == {OccW{1'b0}}) && (fifo_cnt_r == {OccW{1'b0}})) begin
          state_s      = ST_IDLE;
          drain_done_s = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Programming registers, read address, status flags and word counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      begin_r <= 32'd0;
      end_r   <= 32'd0;
      addr_r  <= 32'd0;
      total_r <= {CntWidth{1'b0}};
      count_r <= {CntWidth{1'b0}};
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if (wr_begin_s) begin_r <= dev_wdata_i;
      if (wr_end_s)   end_r   <= dev_wdata_i;
      if (start_go_s) begin
        addr_r  <= begin_r;
        total_r <= words_s[CntWidth-1:0];
      end else if (grant_s) begin
        addr_r <= addr_r + 32'd4;
      end
      if (start_s) begin
        count_r <= {CntWidth{1'b0}};
        done_r  <= start_bad_s || start_empty_s;
        err_r   <= start_bad_s;
      end else begin
        if (pop_s)                 count_r <= count_r + CntWidth'(1);
        if (drain_done_s)          done_r  <= 1'b1;
        if (push_s && host_err_i)  err_r   <= 1'b1;
      end
    end
  end

  // Outstanding read counter and FIFO occupancy/pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst_r    <= {OccW{1'b0}};
      fifo_cnt_r <= {OccW{1'b0}};
      wr_ptr_r   <= {PtrW{1'b0}};
      rd_ptr_r   <= {PtrW{1'b0}};
    end else begin
      case ({grant_s, push_s})
        2'b10:   outst_r <= outst_r + OccW'(1);
        2'b01:   outst_r <= outst_r - OccW'(1);
        default: outst_r <= outst_r;
      endcase
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + OccW'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - OccW'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
      if (push_s) wr_ptr_r <= wr_ptr_r + PtrW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PtrW'(1);
    end
  end

  // FIFO storage; a failed read is replaced by a recognisable poison word.
  always_ff @(posedge clk_i) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= host_err_i ? 32'hDEAD_BEEF : host_rdata_i;
  end

  // Device response, one cycle after the request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dev_rvalid_r <= 1'b0;
      dev_rdata_r  <= 32'd0;
      dev_err_r    <= 1'b0;
    end else begin
      dev_rvalid_r <= dev_req_i;
      dev_rdata_r  <= dev_rdata_s;
      dev_err_r    <= dev_err_s;
    end
  end

  assign dev_rvalid_o = dev_rvalid_r;
  assign dev_rdata_o  = dev_rdata_r;
  assign dev_err_o    = dev_err_r;
  assign host_req_o   = host_req_s;
  assign host_addr_o  = addr_r;
  assign sig_valid_o  = sig_valid_s;
  assign sig_data_o   = sig_valid_s ? fifo_mem_r[rd_ptr_r] : 32'd0;
  assign sig_last_o   = sig_valid_s && (count_r == (total_r - CntWidth'(1)));

endmodule

// File: tb/tb_sig_dump_dma.sv
// Bench for sig_dump_dma: RAM/bus model, random sink, reference stream check.
module tb_sig_dump_dma;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        dev_req_i = 1'b0, dev_we_i = 1'b0;
  logic [31:0] dev_addr_i = 32'd0, dev_wdata_i = 32'd0;
  logic [3:0]  dev_be_i = 4'hF;
  logic        dev_rvalid_o, dev_err_o;
  logic [31:0] dev_rdata_o;
  logic        host_req_o, host_gnt_i = 1'b0;
  logic [31:0] host_addr_o;
  logic        host_rvalid_i = 1'b0, host_err_i = 1'b0;
  logic [31:0] host_rdata_i = 32'd0;
  logic        sig_valid_o, sig_ready_i = 1'b0, sig_last_o;
  logic [31:0] sig_data_o;

  always #5 clk = ~clk;

  sig_dump_dma #(.FifoDepth(4), .CntWidth(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .dev_req_i(dev_req_i), .dev_we_i(dev_we_i), .dev_addr_i(dev_addr_i),
    .dev_be_i(dev_be_i), .dev_wdata_i(dev_wdata_i),
    .dev_rvalid_o(dev_rvalid_o), .dev_rdata_o(dev_rdata_o), .dev_err_o(dev_err_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
    .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
    .sig_valid_o(sig_valid_o), .sig_ready_i(sig_ready_i),
    .sig_data_o(sig_data_o), .sig_last_o(sig_last_o)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  // Bus/RAM and sink model controls
  logic [31:0] pend_q[$];
  logic [31:0] beat_d[$];
  bit          beat_l[$];
  int          n_grants = 0;
  int          n_req = 0;
  int          gnt_limit = 32'h7FFF_FFFF;
  bit          gnt_rand = 1'b0, rv_en = 1'b1, rv_rand = 1'b0;
  int          rdy_mode = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] bus_a;
  bit          stall_prev = 1'b0;
  logic [31:0] stall_data = 32'd0;

  // RAM responder (in-order, >=1 cycle latency), arbiter and stream sink
  always @(negedge clk) begin
    if (rv_en && pend_q.size() > 0 && (!rv_rand || $urandom_range(0, 1) == 1)) begin
      bus_a = pend_q.pop_front();
      host_rvalid_i = 1'b1;
      host_rdata_i  = ram_word(bus_a);
      host_err_i    = (bus_a == err_addr);
    end else begin
      host_rvalid_i = 1'b0;
      host_rdata_i  = $urandom;
      host_err_i    = 1'b0;
    end
    if (host_req_o) n_req++;
    if (host_req_o && n_grants < gnt_limit && (!gnt_rand || $urandom_range(0, 2) != 0)) begin
      host_gnt_i = 1'b1;
      pend_q.push_back(host_addr_o);
      n_grants++;
    end else begin
      host_gnt_i = 1'b0;
    end
    if (stall_prev) begin
      check("stall_valid", {31'd0, sig_valid_o}, 32'd1);
      check("stall_data", sig_data_o, stall_data);
    end
    case (rdy_mode)
      0:       sig_ready_i = 1'b1;
      1:       sig_ready_i = ($urandom_range(0, 1) == 1);
      default: sig_ready_i = 1'b0;
    endcase
    if (sig_valid_o && sig_ready_i) begin
      beat_d.push_back(sig_data_o);
      beat_l.push_back(sig_last_o);
    end
    stall_prev = sig_valid_o && !sig_ready_i;
    stall_data = sig_data_o;
  end

  task automatic dev_acc(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
    @(negedge clk);
    dev_req_i = 1'b1; dev_we_i = we; dev_addr_i = addr; dev_be_i = be; dev_wdata_i = wd;
    @(negedge clk);
    dev_req_i = 1'b0; dev_we_i = 1'b0;
    check("dev_rvalid", {31'd0, dev_rvalid_o}, 32'd1);
    rd = dev_rdata_o;
    er = dev_err_o;
  endtask

  task automatic dev_wr(input logic [31:0] addr, input logic [31:0] wd, input logic exp_err);
    logic [31:0] rd;
    logic er;
    dev_acc(1'b1, addr, 4'hF, wd, rd, er);
    check($sformatf("wr_err@%h", addr), {31'd0, er}, {31'd0, exp_err});
  endtask

  task automatic dev_rd(input logic [31:0] addr, output logic [31:0] rd, output logic er);
    dev_acc(1'b0, addr, 4'hF, 32'd0, rd, er);
  endtask

  task automatic wait_done();
    logic [31:0] st;
    logic er;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1500 && !ok; i++) begin
      dev_rd(32'hC, st, er);
      if (st[1]) ok = 1'b1;
    end
    check("done_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic start_dump(input logic [31:0] b, input int nw, input logic [31:0] ea);
    beat_d.delete();
    beat_l.delete();
    err_addr = ea;
    dev_wr(32'h0, b, 1'b0);
    dev_wr(32'h4, b + 32'(4 * nw), 1'b0);
    dev_wr(32'h8, 32'd1, 1'b0);
  endtask

  task automatic finish_dump(input logic [31:0] b, input int nw, input logic [31:0] ea,
                             input string tag);
    logic [31:0] rd, a, exp;
    logic er;
    bit   any_err;
    wait_done();
    check({tag, "_nbeats"}, 32'(beat_d.size()), 32'(nw));
    any_err = 1'b0;
    for (int i = 0; i < nw; i++) begin
      a = b + 32'(4 * i);
      if (a == ea) any_err = 1'b1;
      exp = (a == ea) ? 32'hDEAD_BEEF : ram_word(a);
      if (i < beat_d.size()) begin
        check($sformatf("%s_beat%0d", tag, i), beat_d[i], exp);
        check($sformatf("%s_last%0d", tag, i), {31'd0, beat_l[i]}, {31'd0, (i == nw - 1)});
      end
    end
    dev_rd(32'hC, rd, er);
    check({tag, "_status"}, rd, {29'd0, any_err, 1'b1, 1'b0});
    dev_rd(32'h10, rd, er);
    check({tag, "_count"}, rd, 32'(nw));
  endtask

  initial begin
    logic [31:0] rd, b, ea;
    logic er;
    int g0, r0, nw;
    bit ok;

    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_req", {31'd0, host_req_o}, 32'd0);
    check("rst_valid", {31'd0, sig_valid_o}, 32'd0);
    dev_rd(32'hC, rd, er);
    check("rst_status", rd, 32'd0);
    dev_rd(32'h10, rd, er);
    check("rst_count", rd, 32'd0);
    dev_rd(32'h0, rd, er);
    check("rst_begin", rd, 32'd0);

    // Basic 4-word dump
    start_dump(32'h100, 4, 32'hFFFF_FFFF);
    finish_dump(32'h100, 4, 32'hFFFF_FFFF, "basic");

    // Sink stalled: only FifoDepth reads may be issued
    rdy_mode = 2;
    g0 = n_grants;
    start_dump(32'h100, 8, 32'hFFFF_FFFF);
    repeat (20) @(negedge clk);
    check("stall_grants", 32'(n_grants - g0), 32'd4);
    check("stall_req_low", {31'd0, host_req_o}, 32'd0);
    rdy_mode = 0;
    finish_dump(32'h100, 8, 32'hFFFF_FFFF, "stall");

    // Bad window and empty window
    r0 = n_req;
    dev_wr(32'h0, 32'h104, 1'b0);
    dev_wr(32'h4, 32'h100, 1'b0);
    dev_wr(32'h8, 32'd1, 1'b0);
    dev_rd(32'hC, rd, er);
    check("bad_status", rd, 32'h6);
    beat_d.delete();
    dev_wr(32'h0, 32'h200, 1'b0);
    dev_wr(32'h4, 32'h200, 1'b0);
    dev_wr(32'h8, 32'd1, 1'b0);
    dev_rd(32'hC, rd, er);
    check("empty_status", rd, 32'h2);
    repeat (5) @(negedge clk);
    check("empty_beats", 32'(beat_d.size()), 32'd0);
    check("bad_no_req", 32'(n_req - r0), 32'd0);

    // Read error on second word
    start_dump(32'h100, 4, 32'h104);
    finish_dump(32'h100, 4, 32'h104, "rderr");

    // Register access while busy, unmapped offset, CTRL readback
    rdy_mode = 2;
    start_dump(32'h100, 8, 32'hFFFF_FFFF);
    dev_wr(32'h0, 32'h300, 1'b1);
    dev_rd(32'h0, rd, er);
    check("busy_begin", rd, 32'h100);
    dev_rd(32'h1C, rd, er);
    check("unmap_rdata", rd, 32'd0);
    check("unmap_err", {31'd0, er}, 32'd1);
    dev_rd(32'h8, rd, er);
    check("ctrl_rdata", rd, 32'd0);
    check("ctrl_err", {31'd0, er}, 32'd0);
    dev_rd(32'hC, rd, er);
    check("busy_status", rd, 32'h1);
    dev_acc(1'b1, 32'h0, 4'h3, 32'h0, rd, er);
    check("partial_be_err", {31'd0, er}, 32'd1);
    rdy_mode = 0;
    finish_dump(32'h100, 8, 32'hFFFF_FFFF, "busy");

    // Randomized dumps
    for (int it = 0; it < 25; it++) begin
      rdy_mode = $urandom_range(0, 1);
      gnt_rand = ($urandom_range(0, 1) == 1);
      rv_rand  = ($urandom_range(0, 1) == 1);
      nw = $urandom_range(1, 12);
      b  = 32'h1000 + 32'($urandom_range(0, 1023)) * 32'd4;
      ea = ($urandom_range(0, 1) == 1) ? b + 32'(4 * $urandom_range(0, nw - 1)) : 32'hFFFF_FFFF;
      start_dump(b, nw, ea);
      finish_dump(b, nw, ea, $sformatf("rnd%0d", it));
    end
    rdy_mode = 0; gnt_rand = 1'b0; rv_rand = 1'b0;

    // Reset mid-RUN with two reads outstanding
    rv_en = 1'b0;
    gnt_limit = n_grants + 2;
    start_dump(32'h400, 16, 32'hFFFF_FFFF);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (n_grants >= gnt_limit) ok = 1'b1;
    end
    check("rst_two_outstanding", {31'd0, ok}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("mid_rst_req", {31'd0, host_req_o}, 32'd0);
    check("mid_rst_addr", host_addr_o, 32'd0);
    check("mid_rst_valid", {31'd0, sig_valid_o}, 32'd0);
    check("mid_rst_data", sig_data_o, 32'd0);
    check("mid_rst_last", {31'd0, sig_last_o}, 32'd0);
    check("mid_rst_dev", {30'd0, dev_rvalid_o, dev_err_o}, 32'd0);
    beat_d.delete();
    rv_en = 1'b1;
    gnt_limit = 32'h7FFF_FFFF;
    repeat (10) @(negedge clk);
    check("late_rvalid_beats", 32'(beat_d.size()), 32'd0);
    check("late_rvalid_drained", 32'(pend_q.size()), 32'd0);
    dev_rd(32'hC, rd, er);
    check("post_rst_status", rd, 32'd0);
    dev_rd(32'h10, rd, er);
    check("post_rst_count", rd, 32'd0);
    start_dump(32'h100, 4, 32'hFFFF_FFFF);
    finish_dump(32'h100, 4, 32'hFFFF_FFFF, "recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
